// File: rtl/unit_test_result_pkg.sv
// Shared types for the unit-test result tracker: verdict codes, FSM states,
// the default-width result record and the verdict rule.
package unit_test_result_pkg;

  localparam int ID_W_DEF  = 8;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    VERDICT_PASS    = 2'd0,
    VERDICT_FAIL    = 2'd1,
    VERDICT_EMPTY   = 2'd2,
    VERDICT_TIMEOUT = 2'd3
  } verdict_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_STALL   = 2'd2
  } state_e;

  typedef struct packed {
    logic [ID_W_DEF-1:0]  id;
    logic [CNT_W_DEF-1:0] pass_cnt;
    logic [CNT_W_DEF-1:0] fail_cnt;
    verdict_e             verdict;
  } result_rec_t;

  // Any failing check dominates; a test with no checks at all is EMPTY.
  function automatic verdict_e calc_verdict(input logic any_fail, input logic any_pass);
    if (any_fail)      return VERDICT_FAIL;
    else if (!any_pass) return VERDICT_EMPTY;
    else               return VERDICT_PASS;
  endfunction

endpackage

// File: rtl/unit_test_result_fifo.sv
// Synchronous FIFO of result records. A push is accepted when not full, or
// when full but a pop happens in the same cycle (the pop frees the slot).
module unit_test_result_fifo
  import unit_test_result_pkg::*;
#(
  parameter type rec_t = result_rec_t,
  parameter int  DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  rec_t push_data,
  input  logic pop,
  output rec_t head,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  rec_t        mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  // Storage write; contents need no reset since empty gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  // Read/write pointers with a wrap bit to tell full from empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/unit_test_result_tracker.sv
// Unit-test result tracker: follows start/check/end events from the on-chip
// harness, counts checks per test and queues one verdict record per test to
// the logger over valid/ready.
// Handshake: a record transfers in a cycle where res_valid && res_ready;
// while res_valid is high and res_ready low, res_* hold steady.
// Optional watchdog: define UNIT_TEST_TIMEOUT_EN to close silent tests with
// a TIMEOUT verdict after TIMEOUT_CYCLES cycles without a check.
module unit_test_result_tracker
  import unit_test_result_pkg::*;
#(
  parameter int ID_W           = ID_W_DEF,
  parameter int CNT_W          = CNT_W_DEF,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  input  logic [ID_W-1:0]  start_id,
  input  logic             check_valid,
  input  logic             check_pass,
  input  logic             end_valid,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ID_W-1:0]  res_id,
  output logic [CNT_W-1:0] res_pass_cnt,
  output logic [CNT_W-1:0] res_fail_cnt,
  output logic [1:0]       res_verdict,
  output logic [CNT_W-1:0] total_run,
  output logic [CNT_W-1:0] total_failed,
  output logic             proto_err,
  output state_e           dbg_state
);

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [CNT_W-1:0] pass_cnt;
    logic [CNT_W-1:0] fail_cnt;
    verdict_e         verdict;
  } rec_t;

  state_e           state;
  logic [ID_W-1:0]  cur_id;
  logic [CNT_W-1:0] pass_cnt, fail_cnt;
  logic [CNT_W-1:0] pass_nx, fail_nx;
  rec_t             hold_rec, rec_run, push_rec, head;
  logic             fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic             can_push, finish_run, push_failed, wd_expire;

`ifdef UNIT_TEST_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;

  assign wd_expire = (state == ST_RUNNING) && !check_valid && !end_valid &&
                     (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  // Watchdog: counts RUNNING cycles since the start or the latest check.
  always_ff @(posedge clk) begin
    if (rst || state != ST_RUNNING || check_valid) wd_cnt <= '0;
    else if (!wd_expire)                           wd_cnt <= wd_cnt + 1'b1;
  end
`else
  // No watchdog in this build: expiry is constant-false.
  assign wd_expire = (TIMEOUT_CYCLES < 0);
`endif

  assign fifo_pop   = !fifo_empty && res_ready;
  assign can_push   = !fifo_full || fifo_pop;
  assign finish_run = (state == ST_RUNNING) && (end_valid || wd_expire);
  assign fifo_push  = (finish_run || state == ST_STALL) && can_push;

  // Next counts (a check coincident with end is included) and the record.
  always_comb begin
    pass_nx = pass_cnt;
    fail_nx = fail_cnt;
    if (check_valid && check_pass && !(&pass_cnt))  pass_nx = pass_cnt + CNT_W'(1);
    if (check_valid && !check_pass && !(&fail_cnt)) fail_nx = fail_cnt + CNT_W'(1);
    rec_run.id       = cur_id;
    rec_run.pass_cnt = pass_nx;
    rec_run.fail_cnt = fail_nx;
    rec_run.verdict  = wd_expire ? VERDICT_TIMEOUT : calc_verdict(|fail_nx, |pass_nx);
    push_rec    = (state == ST_STALL) ? hold_rec : rec_run;
    push_failed = (push_rec.verdict == VERDICT_FAIL) || (push_rec.verdict == VERDICT_TIMEOUT);
  end

  // Test-sequencing FSM, per-test counters, protocol flag and totals.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      cur_id       <= '0;
      pass_cnt     <= '0;
      fail_cnt     <= '0;
      hold_rec     <= '0;
      proto_err    <= 1'b0;
      total_run    <= '0;
      total_failed <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (check_valid || end_valid) proto_err <= 1'b1;
          if (start_valid) begin
            cur_id   <= start_id;
            pass_cnt <= '0;
            fail_cnt <= '0;
            state    <= ST_RUNNING;
          end
        end
        ST_RUNNING: begin
          pass_cnt <= pass_nx;
          fail_cnt <= fail_nx;
          if (start_valid && !end_valid) proto_err <= 1'b1;
          if (finish_run) begin
            if (can_push) begin
              state <= ST_IDLE;
            end else begin
              hold_rec <= rec_run;
              state    <= ST_STALL;
            end
          end
        end
        ST_STALL: begin
          if (start_valid || check_valid || end_valid) proto_err <= 1'b1;
          if (can_push) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
      if (fifo_push) begin
        if (!(&total_run)) total_run <= total_run + CNT_W'(1);
        if (push_failed && !(&total_failed)) total_failed <= total_failed + CNT_W'(1);
      end
    end
  end

  unit_test_result_fifo #(
    .rec_t (rec_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (push_rec),
    .pop       (fifo_pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Output fields show the FIFO head, zero when nothing is queued.
  always_comb begin
    res_valid    = !fifo_empty;
    res_id       = '0;
    res_pass_cnt = '0;
    res_fail_cnt = '0;
    res_verdict  = '0;
    if (res_valid) begin
      res_id       = head.id;
      res_pass_cnt = head.pass_cnt;
      res_fail_cnt = head.fail_cnt;
      res_verdict  = head.verdict;
    end
  end

  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_unit_test_result_tracker.sv
// Testbench for unit_test_result_tracker: directed scenarios plus random
// event traffic, checked every cycle against a queue-based test model.
module tb_unit_test_result_tracker;
  import unit_test_result_pkg::*;

`ifdef UNIT_TEST_TIMEOUT_EN
  localparam int TO     = 16;
  localparam bit TMO_EN = 1'b1;
`else
  localparam int TO     = 1024;
  localparam bit TMO_EN = 1'b0;
`endif
  localparam int REC_W = 42;
  localparam int DEPTH = 4;
  localparam int CMAX  = 65535;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start_valid = 0, check_valid = 0, check_pass = 0, end_valid = 0, res_ready = 0;
  logic [7:0]  start_id = '0;
  logic        busy, res_valid, proto_err;
  logic [7:0]  res_id;
  logic [15:0] res_pass_cnt, res_fail_cnt, total_run, total_failed;
  logic [1:0]  res_verdict;
  state_e      dbg_state;

  unit_test_result_tracker #(
    .ID_W(8), .CNT_W(16), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_id(start_id),
    .check_valid(check_valid), .check_pass(check_pass), .end_valid(end_valid),
    .busy(busy), .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
    .res_pass_cnt(res_pass_cnt), .res_fail_cnt(res_fail_cnt), .res_verdict(res_verdict),
    .total_run(total_run), .total_failed(total_failed), .proto_err(proto_err),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard / model ----------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [REC_W-1:0] exp_q[$];   // records expected in the output queue, head first
  bit               m_active, m_stall, m_err;
  logic [REC_W-1:0] m_hold;
  logic [7:0]       m_id;
  int               m_pass, m_fail, m_wd, m_run, m_failed;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [REC_W-1:0] mk_rec(input logic [7:0] id, input int p, input int f,
                                              input bit timed_out);
    logic [1:0]  v;
    logic [15:0] p16, f16;
    p16 = p[15:0];
    f16 = f[15:0];
    if (timed_out)   v = 2'd3;
    else if (f != 0) v = 2'd1;
    else if (p == 0) v = 2'd2;
    else             v = 2'd0;
    return {id, p16, f16, v};
  endfunction

  task automatic model_clear();
    exp_q.delete();
    m_active = 0; m_stall = 0; m_err = 0; m_hold = '0; m_id = '0;
    m_pass = 0; m_fail = 0; m_wd = 0; m_run = 0; m_failed = 0;
  endtask

  task automatic model_push(input logic [REC_W-1:0] rec);
    logic [1:0] v;
    v = rec[1:0];
    exp_q.push_back(rec);
    if (m_run < CMAX) m_run++;
    if ((v == 2'd1 || v == 2'd3) && m_failed < CMAX) m_failed++;
  endtask

  task automatic model_finish(input bit timed_out, input bit room);
    logic [REC_W-1:0] rec;
    rec = mk_rec(m_id, m_pass, m_fail, timed_out);
    m_active = 0;
    if (room) model_push(rec);
    else begin m_stall = 1; m_hold = rec; end
  endtask

  // One clock edge of the test-tracking rules, applied to the model.
  task automatic model_step(input bit s, input logic [7:0] sid, input bit c, input bit cp,
                            input bit e, input bit r);
    int sz;
    bit pop, room;
    sz   = exp_q.size();
    pop  = (sz > 0) && r;
    room = (sz < DEPTH) || pop;
    if (pop) void'(exp_q.pop_front());
    if (m_stall) begin
      if (s || c || e) m_err = 1;
      if (room) begin model_push(m_hold); m_stall = 0; end
    end else if (m_active) begin
      if (c) begin
        if (cp) begin if (m_pass < CMAX) m_pass++; end
        else    begin if (m_fail < CMAX) m_fail++; end
        m_wd = 0;
      end else m_wd++;
      if (s && !e) m_err = 1;
      if (e)                            model_finish(1'b0, room);
      else if (TMO_EN && m_wd == TO)    model_finish(1'b1, room);
    end else begin
      if (c || e) m_err = 1;
      if (s) begin m_active = 1; m_id = sid; m_pass = 0; m_fail = 0; m_wd = 0; end
    end
  endtask

  task automatic check_outputs();
    check_eq("busy", busy, m_active || m_stall);
    check_eq("res_valid", res_valid, exp_q.size() != 0);
    if (exp_q.size() != 0)
      check_eq("res_rec", {res_id, res_pass_cnt, res_fail_cnt, res_verdict}, exp_q[0]);
    check_eq("total_run", total_run, m_run);
    check_eq("total_failed", total_failed, m_failed);
    check_eq("proto_err", proto_err, m_err);
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input bit s, input logic [7:0] sid, input bit c, input bit cp,
                       input bit e, input bit r);
    @(negedge clk);
    rst = 0; start_valid = s; start_id = sid; check_valid = c; check_pass = cp;
    end_valid = e; res_ready = r;
    @(posedge clk);
    model_step(s, sid, c, cp, e, r);
    #1 check_outputs();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; start_valid = 0; check_valid = 0; end_valid = 0; res_ready = 0;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    model_clear();
    #1 check_outputs();
    check_eq("rst_res_fields", {res_id, res_pass_cnt, res_fail_cnt, res_verdict}, '0);
  endtask

  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) cycle(0, 8'h00, 0, 0, 0, r);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int ready_pct;
    model_clear();
    do_reset();

    // single passing test, record visible one cycle after end
    cycle(1, 8'h05, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cycle(0, 8'h00, 1, 1, 0, 1);
    cycle(0, 8'h00, 0, 0, 1, 0);
    check_eq("t1_latency_valid", res_valid, 1'b1);
    check_eq("t1_rec", {res_id, res_pass_cnt, res_fail_cnt, res_verdict},
             {8'h05, 16'd3, 16'd0, 2'd0});
    idle(2, 1);

    // failing test, end coincident with a failing check
    cycle(1, 8'h0A, 0, 0, 0, 1);
    cycle(0, 8'h00, 1, 1, 0, 1);
    cycle(0, 8'h00, 1, 0, 0, 1);
    cycle(0, 8'h00, 1, 1, 0, 1);
    cycle(0, 8'h00, 1, 0, 1, 0);
    check_eq("t2_rec", {res_id, res_pass_cnt, res_fail_cnt, res_verdict},
             {8'h0A, 16'd2, 16'd2, 2'd1});
    idle(2, 1);

    // empty test, then a check in IDLE raises the sticky error
    cycle(1, 8'h11, 0, 0, 0, 0);
    cycle(0, 8'h00, 0, 0, 1, 0);
    check_eq("t3_verdict_empty", res_verdict, 2'd2);
    idle(1, 1);
    cycle(0, 8'h00, 1, 1, 0, 1);
    check_eq("t3_proto_err", proto_err, 1'b1);
    idle(3, 1);

    // back-pressure: 5 tests with res_ready low, 5th stalls
    for (int t = 0; t < 5; t++) begin
      cycle(1, 8'(8'h20 + t), 0, 0, 0, 0);
      cycle(0, 8'h00, 1, 1, 0, 0);
      cycle(0, 8'h00, 0, 0, 1, 0);
    end
    check_eq("t4_stall_busy", busy, 1'b1);
    idle(4, 0);
    cycle(0, 8'h00, 0, 0, 0, 1);
    check_eq("t4_stall_released", busy, 1'b0);
    idle(3, 0);
    idle(6, 1);
    check_eq("t4_drained", res_valid, 1'b0);

    // reset in the middle of a test discards it
    cycle(1, 8'h44, 0, 0, 0, 1);
    cycle(0, 8'h00, 1, 1, 0, 1);
    cycle(0, 8'h00, 1, 0, 0, 1);
    do_reset();
    idle(1, 1);
    check_eq("t5_no_record", res_valid, 1'b0);

`ifdef UNIT_TEST_TIMEOUT_EN
    // silent test closed by the watchdog
    cycle(1, 8'h33, 0, 0, 0, 1);
    cycle(0, 8'h00, 1, 1, 0, 1);
    idle(15, 1);
    check_eq("t6_not_yet", res_valid, 1'b0);
    cycle(0, 8'h00, 0, 0, 0, 0);
    check_eq("t6_timeout_rec", {res_id, res_pass_cnt, res_fail_cnt, res_verdict},
             {8'h33, 16'd1, 16'd0, 2'd3});
    idle(2, 1);
`endif

    // random traffic
    do_reset();
    ready_pct = 60;
    for (int i = 0; i < 2000; i++) begin
      if (i % 64 == 0) ready_pct = $urandom_range(10, 95);
      cycle($urandom_range(0, 99) < 12, 8'($urandom_range(0, 255)),
            $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 70,
            $urandom_range(0, 99) < 12, $urandom_range(0, 99) < ready_pct);
    end
    idle(10, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
